id_fwd_stage: RTL and testbench

Parametrised successor of the combinational decode stage. Decodes logic, shift, LUI, SYNC/PREF and LW instructions, and bypasses operands from NUM_FWD prioritised writeback sources. Detects load-use hazards and inserts bubbles. Registers the result into an internal ID/EX pipeline register with stall and flush control. Sits between the IF/ID register and the EX stage.

---
 rtl/id_pkg.sv | 69 ++++++
 rtl/id_fwd_stage_if.sv | 55 +++++
 rtl/id_opnd_mux.sv | 33 +++
 rtl/id_fwd_stage.sv | 185 ++++++++++++++++++
 tb/tb_id_fwd_stage.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/id_pkg.sv
// Shared decode-stage definitions: ALU op/select codes, opcode/funct constants
// and the ID/EX pipeline register payload.
package id_pkg;

    localparam int unsigned ID_DATA_W = 32;
    localparam int unsigned ID_PC_W   = 32;
    localparam int unsigned ID_RA_W   = 5;

    typedef logic [7:0] alu_op_t;
    typedef logic [2:0] alu_sel_t;

    localparam alu_op_t EXE_NOP_OP = 8'b0000_0000;
    localparam alu_op_t EXE_AND_OP = 8'b0010_0100;
    localparam alu_op_t EXE_OR_OP  = 8'b0010_0101;
    localparam alu_op_t EXE_XOR_OP = 8'b0010_0110;
    localparam alu_op_t EXE_NOR_OP = 8'b0010_0111;
    localparam alu_op_t EXE_SLL_OP = 8'b0111_1100;
    localparam alu_op_t EXE_SRL_OP = 8'b0000_0010;
    localparam alu_op_t EXE_SRA_OP = 8'b0000_0011;
    localparam alu_op_t EXE_LW_OP  = 8'b1110_0011;

    localparam alu_sel_t EXE_RES_NOP        = 3'b000;
    localparam alu_sel_t EXE_RES_LOGIC      = 3'b001;
    localparam alu_sel_t EXE_RES_SHIFT      = 3'b010;
    localparam alu_sel_t EXE_RES_LOAD_STORE = 3'b111;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_PREF    = 6'b110011;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_SYNC = 6'b001111;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;

    typedef struct packed {
        logic                 valid;
        logic [ID_PC_W-1:0]   pc;
        alu_op_t              aluop;
        alu_sel_t             alusel;
        logic [ID_DATA_W-1:0] reg1;
        logic [ID_DATA_W-1:0] reg2;
        logic [ID_RA_W-1:0]   waddr;
        logic                 wreg;
        logic                 is_load;
        logic                 inst_invalid;
    } id_ex_t;

    // Empty ID/EX slot used for reset, flush and interlock bubbles.
    function automatic id_ex_t ex_bubble();
        id_ex_t b;
        b        = '0;
        b.aluop  = EXE_NOP_OP;
        b.alusel = EXE_RES_NOP;
        return b;
    endfunction

endpackage

// File: rtl/id_fwd_stage_if.sv
// Decode-stage bus: IF/ID inputs, bypass sources, regfile port and ID/EX outputs.
interface id_fwd_stage_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
);
    import id_pkg::*;

    logic                      if_valid_i;
    logic [PC_W-1:0]           id_pc_i;
    logic [31:0]               id_inst_i;
    logic [NUM_FWD-1:0]        fwd_wreg_i;
    logic [NUM_FWD*RA_W-1:0]   fwd_waddr_i;
    logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i;
    logic                      fwd0_is_load_i;
    logic                      stall_i;
    logic                      flush_i;
    logic [DATA_W-1:0]         reg1_data_i;
    logic [DATA_W-1:0]         reg2_data_i;
    logic                      reg1_ren_o;
    logic                      reg2_ren_o;
    logic [RA_W-1:0]           reg1_addr_o;
    logic [RA_W-1:0]           reg2_addr_o;
    logic                      stallreq_o;
    logic                      ex_valid_o;
    logic [PC_W-1:0]           ex_pc_o;
    alu_op_t                   ex_aluop_o;
    alu_sel_t                  ex_alusel_o;
    logic [DATA_W-1:0]         ex_reg1_o;
    logic [DATA_W-1:0]         ex_reg2_o;
    logic [RA_W-1:0]           ex_waddr_o;
    logic                      ex_wreg_o;
    logic                      ex_is_load_o;
    logic                      ex_inst_invalid_o;
    logic [CNT_W-1:0]          bubble_cnt_o;

    modport slave (
        input  if_valid_i, id_pc_i, id_inst_i, fwd_wreg_i, fwd_waddr_i, fwd_wdata_i,
               fwd0_is_load_i, stall_i, flush_i, reg1_data_i, reg2_data_i,
        output reg1_ren_o, reg2_ren_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
               ex_waddr_o, ex_wreg_o, ex_is_load_o, ex_inst_invalid_o, bubble_cnt_o
    );

    modport master (
        output if_valid_i, id_pc_i, id_inst_i, fwd_wreg_i, fwd_waddr_i, fwd_wdata_i,
               fwd0_is_load_i, stall_i, flush_i, reg1_data_i, reg2_data_i,
        input  reg1_ren_o, reg2_ren_o, reg1_addr_o, reg2_addr_o, stallreq_o,
               ex_valid_o, ex_pc_o, ex_aluop_o, ex_alusel_o, ex_reg1_o, ex_reg2_o,
               ex_waddr_o, ex_wreg_o, ex_is_load_o, ex_inst_invalid_o, bubble_cnt_o
    );

endinterface

// File: rtl/id_opnd_mux.sv
// Per-port operand select: immediate when unread, zero for $0, else
// the lowest-index matching bypass source, falling back to regfile data.
module id_opnd_mux #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_FWD = 2
) (
    input  logic                      ren,
    input  logic [RA_W-1:0]           addr,
    input  logic [DATA_W-1:0]         reg_data,
    input  logic [DATA_W-1:0]         imm,
    input  logic [NUM_FWD-1:0]        fwd_wreg,
    input  logic [NUM_FWD*RA_W-1:0]   fwd_waddr,
    input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata,
    output logic [DATA_W-1:0]         data_c
);

    always_comb begin
        data_c = reg_data;
        if (!ren) begin
            data_c = imm;
        end else if (addr == '0) begin
            data_c = '0;
        end else begin
            // Walk oldest to youngest so the youngest match wins.
            for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
                if (fwd_wreg[i] && (fwd_waddr[i*RA_W +: RA_W] == addr))
                    data_c = fwd_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/id_fwd_stage.sv
// Decode stage with prioritised bypass, load-use interlock and the ID/EX
// pipeline register (flush > stall > interlock bubble > capture).
module id_fwd_stage
    import id_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned RA_W    = 5,
    parameter int unsigned NUM_FWD = 2,
    parameter int unsigned CNT_W   = 16
) (
    input logic           clk,
    input logic           rst,
    id_fwd_stage_if.slave bus
);

    logic [5:0]        op, fn;
    logic [RA_W-1:0]   rs, rt, rd, fwd0_addr;
    logic [4:0]        sa;
    logic [15:0]       imm16;
    alu_op_t           aluop_d;
    alu_sel_t          alusel_d;
    logic              ren1_d, ren2_d, wreg_d, load_d, inv_d;
    logic              ren1_c, ren2_c, stallreq_c;
    logic [RA_W-1:0]   waddr_d;
    logic [DATA_W-1:0] imm_d, opnd1_c, opnd2_c;
    id_ex_t            ex_d, ex_q;
    logic [CNT_W-1:0]  cnt_q;

    assign op    = bus.id_inst_i[31:26];
    assign rs    = RA_W'(bus.id_inst_i[25:21]);
    assign rt    = RA_W'(bus.id_inst_i[20:16]);
    assign rd    = RA_W'(bus.id_inst_i[15:11]);
    assign sa    = bus.id_inst_i[10:6];
    assign fn    = bus.id_inst_i[5:0];
    assign imm16 = bus.id_inst_i[15:0];

    // Instruction decode; anything not recognised stays flagged invalid.
    always_comb begin
        aluop_d  = EXE_NOP_OP;
        alusel_d = EXE_RES_NOP;
        ren1_d   = 1'b0;
        ren2_d   = 1'b0;
        waddr_d  = rd;
        wreg_d   = 1'b0;
        load_d   = 1'b0;
        inv_d    = 1'b1;
        imm_d    = '0;
        unique case (op)
            OP_SPECIAL: begin
                unique case (fn)
                    FN_OR, FN_AND, FN_XOR, FN_NOR, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        ren1_d = 1'b1;
                        ren2_d = 1'b1;
                        wreg_d = 1'b1;
                        inv_d  = 1'b0;
                        unique case (fn)
                            FN_OR:   begin aluop_d = EXE_OR_OP;  alusel_d = EXE_RES_LOGIC; end
                            FN_AND:  begin aluop_d = EXE_AND_OP; alusel_d = EXE_RES_LOGIC; end
                            FN_XOR:  begin aluop_d = EXE_XOR_OP; alusel_d = EXE_RES_LOGIC; end
                            FN_NOR:  begin aluop_d = EXE_NOR_OP; alusel_d = EXE_RES_LOGIC; end
                            FN_SLLV: begin aluop_d = EXE_SLL_OP; alusel_d = EXE_RES_SHIFT; end
                            FN_SRLV: begin aluop_d = EXE_SRL_OP; alusel_d = EXE_RES_SHIFT; end
                            default: begin aluop_d = EXE_SRA_OP; alusel_d = EXE_RES_SHIFT; end
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        if (bus.id_inst_i[25:21] == 5'd0) begin
                            ren2_d   = 1'b1;
                            imm_d    = DATA_W'(sa);
                            wreg_d   = 1'b1;
                            inv_d    = 1'b0;
                            alusel_d = EXE_RES_SHIFT;
                            aluop_d  = (fn == FN_SLL) ? EXE_SLL_OP :
                                       (fn == FN_SRL) ? EXE_SRL_OP : EXE_SRA_OP;
                        end
                    end
                    FN_SYNC: inv_d = 1'b0;
                    default: ;
                endcase
            end
            OP_ORI, OP_ANDI, OP_XORI: begin
                ren1_d   = 1'b1;
                imm_d    = DATA_W'(imm16);
                waddr_d  = rt;
                wreg_d   = 1'b1;
                inv_d    = 1'b0;
                alusel_d = EXE_RES_LOGIC;
                aluop_d  = (op == OP_ORI)  ? EXE_OR_OP :
                           (op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP;
            end
            OP_LUI: begin
                ren1_d   = 1'b1;
                imm_d    = DATA_W'({imm16, 16'h0000});
                waddr_d  = rt;
                wreg_d   = 1'b1;
                inv_d    = 1'b0;
                aluop_d  = EXE_OR_OP;
                alusel_d = EXE_RES_LOGIC;
            end
            OP_LW: begin
                ren1_d   = 1'b1;
                imm_d    = DATA_W'({{16{imm16[15]}}, imm16});
                waddr_d  = rt;
                wreg_d   = 1'b1;
                load_d   = 1'b1;
                inv_d    = 1'b0;
                aluop_d  = EXE_LW_OP;
                alusel_d = EXE_RES_LOAD_STORE;
            end
            OP_PREF: inv_d = 1'b0;
            default: ;
        endcase
    end

    assign ren1_c          = rst & ren1_d;
    assign ren2_c          = rst & ren2_d;
    assign bus.reg1_ren_o  = ren1_c;
    assign bus.reg2_ren_o  = ren2_c;
    assign bus.reg1_addr_o = rst ? rs : '0;
    assign bus.reg2_addr_o = rst ? rt : '0;

    id_opnd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_opnd1 (
        .ren(ren1_c), .addr(rs), .reg_data(bus.reg1_data_i), .imm(imm_d),
        .fwd_wreg(bus.fwd_wreg_i), .fwd_waddr(bus.fwd_waddr_i),
        .fwd_wdata(bus.fwd_wdata_i), .data_c(opnd1_c)
    );

    id_opnd_mux #(.DATA_W(DATA_W), .RA_W(RA_W), .NUM_FWD(NUM_FWD)) u_opnd2 (
        .ren(ren2_c), .addr(rt), .reg_data(bus.reg2_data_i), .imm(imm_d),
        .fwd_wreg(bus.fwd_wreg_i), .fwd_waddr(bus.fwd_waddr_i),
        .fwd_wdata(bus.fwd_wdata_i), .data_c(opnd2_c)
    );

    // Load in EX whose result is needed now: bubble and let source 1 bypass it next cycle.
    assign fwd0_addr  = bus.fwd_waddr_i[RA_W-1:0];
    assign stallreq_c = bus.if_valid_i & bus.fwd0_is_load_i & bus.fwd_wreg_i[0] &
                        (fwd0_addr != '0) &
                        ((ren1_c & (rs == fwd0_addr)) | (ren2_c & (rt == fwd0_addr)));
    assign bus.stallreq_o = stallreq_c;

    always_comb begin
        ex_d              = ex_bubble();
        ex_d.valid        = bus.if_valid_i;
        ex_d.pc           = ID_PC_W'(bus.id_pc_i);
        ex_d.aluop        = aluop_d;
        ex_d.alusel       = alusel_d;
        ex_d.reg1         = ID_DATA_W'(opnd1_c);
        ex_d.reg2         = ID_DATA_W'(opnd2_c);
        ex_d.waddr        = ID_RA_W'(waddr_d);
        ex_d.wreg         = wreg_d & bus.if_valid_i;
        ex_d.is_load      = load_d & bus.if_valid_i;
        ex_d.inst_invalid = inv_d & bus.if_valid_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ex_q  <= ex_bubble();
            cnt_q <= '0;
        end else if (bus.flush_i) begin
            ex_q <= ex_bubble();
        end else if (!bus.stall_i) begin
            if (stallreq_c) begin
                ex_q <= ex_bubble();
                if (cnt_q != '1)
                    cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                ex_q <= ex_d;
            end
        end
    end

    assign bus.ex_valid_o        = ex_q.valid;
    assign bus.ex_pc_o           = PC_W'(ex_q.pc);
    assign bus.ex_aluop_o        = ex_q.aluop;
    assign bus.ex_alusel_o       = ex_q.alusel;
    assign bus.ex_reg1_o         = DATA_W'(ex_q.reg1);
    assign bus.ex_reg2_o         = DATA_W'(ex_q.reg2);
    assign bus.ex_waddr_o        = RA_W'(ex_q.waddr);
    assign bus.ex_wreg_o         = ex_q.wreg;
    assign bus.ex_is_load_o      = ex_q.is_load;
    assign bus.ex_inst_invalid_o = ex_q.inst_invalid;
    assign bus.bubble_cnt_o      = cnt_q;

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: decode/forward vector table plus
// interlock, stall/flush and reset sequences.
module tb_id_fwd_stage;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   exp_cnt;

    id_fwd_stage_if #(.DATA_W(32), .PC_W(32), .RA_W(5), .NUM_FWD(2), .CNT_W(16)) bus ();

    id_fwd_stage #(.DATA_W(32), .PC_W(32), .RA_W(5), .NUM_FWD(2), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic        vld;
        logic [1:0]  fw;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        ld;
        logic        e_sr;
        logic        e_v;
        logic [31:0] e_r1;
        logic [31:0] e_r2;
        logic [4:0]  e_wa;
        logic        e_w;
        logic [7:0]  e_op;
        logic [2:0]  e_sel;
        logic        e_inv;
        logic        e_ld;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] inst, input logic vld, input logic [1:0] fw,
                         input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1, input logic ld);
        bus.id_inst_i      = inst;
        bus.if_valid_i     = vld;
        bus.fwd_wreg_i     = fw;
        bus.fwd_waddr_i    = {a1, a0};
        bus.fwd_wdata_i    = {d1, d0};
        bus.fwd0_is_load_i = ld;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;

        //            inst          vld  fw     a0     d0            a1     d1          ld    sr    v     r1            r2            wa     w     op      sel   inv   ld
        vecs[0]  = '{32'h34011234, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,        32'h1234,     5'd1, 1'b1, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[1]  = '{32'h00221825, 1'b1, 2'b11, 5'd1,  32'hAAAA,     5'd1, 32'hBBBB,   1'b0, 1'b0, 1'b1, 32'hAAAA,     32'h22,       5'd3, 1'b1, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[2]  = '{32'h00221825, 1'b1, 2'b10, 5'd5,  32'h9999,     5'd2, 32'h5,      1'b0, 1'b0, 1'b1, 32'h11,       32'h5,        5'd3, 1'b1, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[3]  = '{32'h34011234, 1'b1, 2'b01, 5'd0,  32'hFFFFFFFF, 5'd0, 32'h0,      1'b1, 1'b0, 1'b1, 32'h0,        32'h1234,     5'd1, 1'b1, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[4]  = '{32'hFC000000, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        5'd0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        vecs[5]  = '{32'h8C44FFFC, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h11,       32'hFFFFFFFC, 5'd4, 1'b1, 8'hE3, 3'd7, 1'b0, 1'b1};
        vecs[6]  = '{32'h000228C0, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h3,        32'h22,       5'd5, 1'b1, 8'h7C, 3'd2, 1'b0, 1'b0};
        vecs[7]  = '{32'h3C06ABCD, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,        32'hABCD0000, 5'd6, 1'b1, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[8]  = '{32'h00221825, 1'b0, 2'b01, 5'd1,  32'h12345678, 5'd0, 32'h0,      1'b1, 1'b0, 1'b0, 32'h12345678, 32'h22,       5'd3, 1'b0, 8'h25, 3'd1, 1'b0, 1'b0};
        vecs[9]  = '{32'h386700F0, 1'b1, 2'b10, 5'd0,  32'h0,        5'd3, 32'h0F0F,   1'b0, 1'b0, 1'b1, 32'h0F0F,     32'hF0,       5'd7, 1'b1, 8'h26, 3'd1, 1'b0, 1'b0};
        vecs[10] = '{32'h012A4027, 1'b1, 2'b01, 5'd10, 32'h77,       5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h11,       32'h77,       5'd8, 1'b1, 8'h27, 3'd1, 1'b0, 1'b0};
        vecs[11] = '{32'h0000000F, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        5'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        vecs[12] = '{32'h002228C3, 1'b1, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b1, 32'h0,        32'h0,        5'd5, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
        vecs[13] = '{32'hFC000000, 1'b0, 2'b00, 5'd0,  32'h0,        5'd0, 32'h0,      1'b0, 1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};

        // Reset with a live hazard on the inputs: everything must read zero.
        rst             = 1'b0;
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.id_pc_i     = 32'h0000_0400;
        bus.reg1_data_i = 32'h11;
        bus.reg2_data_i = 32'h22;
        drive(32'h00221825, 1'b1, 2'b01, 5'd1, 32'hDEAD, 5'd0, 32'h0, 1'b1);
        repeat (2) step();
        check("rst.stallreq", 32'(bus.stallreq_o), 32'h0);
        check("rst.reg1_ren", 32'(bus.reg1_ren_o), 32'h0);
        check("rst.reg1_addr", 32'(bus.reg1_addr_o), 32'h0);
        check("rst.valid", 32'(bus.ex_valid_o), 32'h0);
        check("rst.pc", bus.ex_pc_o, 32'h0);
        check("rst.reg2", bus.ex_reg2_o, 32'h0);
        check("rst.wreg", 32'(bus.ex_wreg_o), 32'h0);
        check("rst.aluop", 32'(bus.ex_aluop_o), 32'h0);
        check("rst.alusel", 32'(bus.ex_alusel_o), 32'h0);
        check("rst.bubble_cnt", 32'(bus.bubble_cnt_o), 32'h0);
        rst = 1'b1;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].inst, vecs[i].vld, vecs[i].fw, vecs[i].a0, vecs[i].d0,
                  vecs[i].a1, vecs[i].d1, vecs[i].ld);
            bus.id_pc_i = 32'h0000_0400 + 32'(i) * 32'd4;
            #1;
            check($sformatf("v%0d.stallreq", i), 32'(bus.stallreq_o), 32'(vecs[i].e_sr));
            step();
            check($sformatf("v%0d.valid", i), 32'(bus.ex_valid_o), 32'(vecs[i].e_v));
            check($sformatf("v%0d.pc", i), bus.ex_pc_o, 32'h0000_0400 + 32'(i) * 32'd4);
            check($sformatf("v%0d.reg1", i), bus.ex_reg1_o, vecs[i].e_r1);
            check($sformatf("v%0d.reg2", i), bus.ex_reg2_o, vecs[i].e_r2);
            check($sformatf("v%0d.waddr", i), 32'(bus.ex_waddr_o), 32'(vecs[i].e_wa));
            check($sformatf("v%0d.wreg", i), 32'(bus.ex_wreg_o), 32'(vecs[i].e_w));
            check($sformatf("v%0d.aluop", i), 32'(bus.ex_aluop_o), 32'(vecs[i].e_op));
            check($sformatf("v%0d.alusel", i), 32'(bus.ex_alusel_o), 32'(vecs[i].e_sel));
            check($sformatf("v%0d.invalid", i), 32'(bus.ex_inst_invalid_o), 32'(vecs[i].e_inv));
            check($sformatf("v%0d.is_load", i), 32'(bus.ex_is_load_o), 32'(vecs[i].e_ld));
        end
        check("table.bubble_cnt", 32'(bus.bubble_cnt_o), 32'(exp_cnt));

        // Load-use on rs: one bubble, then capture with source-1 data.
        drive(32'h00221825, 1'b1, 2'b01, 5'd1, 32'hDEAD, 5'd0, 32'h0, 1'b1);
        #1;
        check("lu_rs.stallreq", 32'(bus.stallreq_o), 32'h1);
        check("lu_rs.reg1_addr", 32'(bus.reg1_addr_o), 32'h1);
        step();
        exp_cnt++;
        check("lu_rs.bubble_valid", 32'(bus.ex_valid_o), 32'h0);
        check("lu_rs.bubble_wreg", 32'(bus.ex_wreg_o), 32'h0);
        check("lu_rs.bubble_cnt", 32'(bus.bubble_cnt_o), 32'(exp_cnt));
        drive(32'h00221825, 1'b1, 2'b10, 5'd0, 32'h0, 5'd1, 32'hCCCC, 1'b0);
        #1;
        check("lu_rs.release", 32'(bus.stallreq_o), 32'h0);
        step();
        check("lu_rs.valid", 32'(bus.ex_valid_o), 32'h1);
        check("lu_rs.reg1", bus.ex_reg1_o, 32'hCCCC);
        check("lu_rs.cnt_hold", 32'(bus.bubble_cnt_o), 32'(exp_cnt));

        // Load-use on rt.
        drive(32'h00221825, 1'b1, 2'b01, 5'd2, 32'hDEAD, 5'd0, 32'h0, 1'b1);
        #1;
        check("lu_rt.stallreq", 32'(bus.stallreq_o), 32'h1);
        step();
        exp_cnt++;
        check("lu_rt.valid", 32'(bus.ex_valid_o), 32'h0);
        check("lu_rt.bubble_cnt", 32'(bus.bubble_cnt_o), 32'(exp_cnt));

        // stall_i holds everything, even with an interlock pending; then flush wins over stall.
        drive(32'h34011234, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        step();
        check("stall.pre_valid", 32'(bus.ex_valid_o), 32'h1);
        bus.stall_i = 1'b1;
        drive(32'h00221825, 1'b1, 2'b01, 5'd1, 32'hDEAD, 5'd0, 32'h0, 1'b1);
        #1;
        check("stall.stallreq", 32'(bus.stallreq_o), 32'h1);
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("stall%0d.valid", c), 32'(bus.ex_valid_o), 32'h1);
            check($sformatf("stall%0d.reg2", c), bus.ex_reg2_o, 32'h1234);
            check($sformatf("stall%0d.waddr", c), 32'(bus.ex_waddr_o), 32'h1);
            check($sformatf("stall%0d.cnt", c), 32'(bus.bubble_cnt_o), 32'(exp_cnt));
        end
        bus.flush_i = 1'b1;
        drive(32'h34011234, 1'b1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        step();
        check("flush.valid", 32'(bus.ex_valid_o), 32'h0);
        check("flush.wreg", 32'(bus.ex_wreg_o), 32'h0);
        check("flush.aluop", 32'(bus.ex_aluop_o), 32'h0);
        check("flush.cnt", 32'(bus.bubble_cnt_o), 32'(exp_cnt));
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;

        // Reset asserted mid-interlock clears the register and the counter.
        step();
        check("rst2.pre_valid", 32'(bus.ex_valid_o), 32'h1);
        drive(32'h00221825, 1'b1, 2'b01, 5'd1, 32'hDEAD, 5'd0, 32'h0, 1'b1);
        #1;
        check("rst2.stallreq_pre", 32'(bus.stallreq_o), 32'h1);
        rst = 1'b0;
        #1;
        check("rst2.stallreq", 32'(bus.stallreq_o), 32'h0);
        step();
        check("rst2.valid", 32'(bus.ex_valid_o), 32'h0);
        check("rst2.reg2", bus.ex_reg2_o, 32'h0);
        check("rst2.waddr", 32'(bus.ex_waddr_o), 32'h0);
        check("rst2.pc", bus.ex_pc_o, 32'h0);
        check("rst2.bubble_cnt", 32'(bus.bubble_cnt_o), 32'h0);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
